// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the asynchronous-read memory bus between the CPU core
// and a DMA/debug loader port. It stretches accesses to the slow region with
// wait states and separates every change of bus master with a dead cycle.
module bus_arbiter #(
    parameter logic [15:0] SLOW_BASE     = 16'hC000,
    parameter int          SLOW_WAIT     = 2,
    parameter int          DMA_MAX_BURST = 16
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        cpu_READ_write,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_rdy,
    input  logic        dma_req,
    input  logic        dma_READ_write,
    input  logic [15:0] dma_address,
    input  logic [7:0]  dma_wdata,
    output logic        dma_gnt,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_cs,
    input  logic [7:0]  mem_rdata
);

    localparam int WAIT_W  = $clog2(SLOW_WAIT + 1);
    localparam int BURST_W = $clog2(DMA_MAX_BURST + 1);
    localparam logic [WAIT_W-1:0]  WAIT_DONE  = WAIT_W'(SLOW_WAIT);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(DMA_MAX_BURST - 1);

    typedef enum logic [1:0] {
        CPU_OWN  = 2'd0,
        HANDOVER = 2'd1,
        DMA_OWN  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [WAIT_W-1:0]    wait_cnt_r;
    logic [BURST_W-1:0]   burst_cnt_r;
    logic                 starve_r;

    logic                 cpu_active_s;
    logic                 dma_active_s;
    logic [15:0]          sel_addr_s;
    logic [7:0]           sel_wdata_s;
    logic                 sel_rw_s;
    logic                 slow_s;
    logic                 wait_met_s;
    logic                 cpu_done_s;
    logic                 dma_done_s;
    logic                 last_beat_s;
    logic                 master_change_s;

    // Addresses at or above the slow base need wait states.
    function automatic logic is_slow(input logic [15:0] addr);
        return (addr >= SLOW_BASE);
    endfunction

    // Select the active master's request and decide whether it completes now.
    always_comb begin
        cpu_active_s = (state_r == CPU_OWN);
        dma_active_s = (state_r == DMA_OWN);
        if (dma_active_s) begin
            sel_addr_s  = dma_address;
            sel_wdata_s = dma_wdata;
            sel_rw_s    = dma_READ_write;
        end else begin
            sel_addr_s  = cpu_address;
            sel_wdata_s = cpu_data_out;
            sel_rw_s    = cpu_READ_write;
        end
        slow_s = is_slow(sel_addr_s);
        if (slow_s) begin
            wait_met_s = (wait_cnt_r == WAIT_DONE);
        end else begin
            wait_met_s = 1'b1;
        end
        cpu_done_s      = cpu_active_s && wait_met_s;
        // A dropped request abandons the beat, even one whose wait has elapsed.
        dma_done_s      = dma_active_s && dma_req && wait_met_s;
        last_beat_s     = dma_done_s && (burst_cnt_r == BURST_LAST);
        master_change_s = (state_next_s != state_r);
    end

    // FSM state register.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_r <= CPU_OWN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic: grants only on completing CPU reads, so writes never split.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            CPU_OWN: begin
                if (dma_req && cpu_READ_write && cpu_done_s && !starve_r) begin
                    state_next_s = HANDOVER;
                end else begin
                    state_next_s = CPU_OWN;
                end
            end
            HANDOVER: begin
                state_next_s = DMA_OWN;
            end
            DMA_OWN: begin
                if (!dma_req || last_beat_s) begin
                    state_next_s = RELEASE;
                end else begin
                    state_next_s = DMA_OWN;
                end
            end
            RELEASE: begin
                state_next_s = CPU_OWN;
            end
            default: begin
                state_next_s = CPU_OWN;
            end
        endcase
    end

    // FSM outputs: strobes follow the owning master, dead cycles keep the bus idle.
    always_comb begin
        cpu_rdy     = cpu_done_s;
        dma_ack     = dma_done_s;
        dma_gnt     = dma_active_s;
        mem_cs      = cpu_active_s || dma_active_s;
        mem_we      = !sel_rw_s && (cpu_done_s || dma_done_s) && !reset;
        mem_address = sel_addr_s;
        mem_wdata   = sel_wdata_s;
        cpu_data_in = mem_rdata;
        dma_rdata   = mem_rdata;
    end

    // Wait-state counter for slow accesses; restarts on completion or master change.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (master_change_s || !(cpu_active_s || dma_active_s) || !slow_s
                     || cpu_done_s || dma_done_s) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end
    end

    // Beats granted in the current DMA tenure.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            burst_cnt_r <= {BURST_W{1'b0}};
        end else if (state_r == HANDOVER) begin
            burst_cnt_r <= {BURST_W{1'b0}};
        end else if (dma_done_s) begin
            burst_cnt_r <= burst_cnt_r + BURST_W'(1);
        end else begin
            burst_cnt_r <= burst_cnt_r;
        end
    end

    // Starvation guard: after a full burst the CPU must complete one access first.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            starve_r <= 1'b0;
        end else if (last_beat_s) begin
            starve_r <= 1'b1;
        end else if (cpu_done_s) begin
            starve_r <= 1'b0;
        end else begin
            starve_r <= starve_r;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: directed scenarios followed by a random phase,
// all compared cycle by cycle against a behavioural bus-ownership model.
module tb_bus_arbiter;

    localparam logic [15:0] SLOW_BASE     = 16'hC000;
    localparam int          SLOW_WAIT     = 2;
    localparam int          DMA_MAX_BURST = 16;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        cpu_READ_write;
    logic [15:0] cpu_address;
    logic [7:0]  cpu_data_out;
    logic [7:0]  cpu_data_in;
    logic        cpu_rdy;
    logic        dma_req;
    logic        dma_READ_write;
    logic [15:0] dma_address;
    logic [7:0]  dma_wdata;
    logic        dma_gnt;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_cs;
    logic [7:0]  mem_rdata;

    bus_arbiter #(
        .SLOW_BASE    (SLOW_BASE),
        .SLOW_WAIT    (SLOW_WAIT),
        .DMA_MAX_BURST(DMA_MAX_BURST)
    ) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .cpu_READ_write(cpu_READ_write),
        .cpu_address   (cpu_address),
        .cpu_data_out  (cpu_data_out),
        .cpu_data_in   (cpu_data_in),
        .cpu_rdy       (cpu_rdy),
        .dma_req       (dma_req),
        .dma_READ_write(dma_READ_write),
        .dma_address   (dma_address),
        .dma_wdata     (dma_wdata),
        .dma_gnt       (dma_gnt),
        .dma_ack       (dma_ack),
        .dma_rdata     (dma_rdata),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_cs        (mem_cs),
        .mem_rdata     (mem_rdata)
    );

    always #5 clk_in = ~clk_in;

    int n_err    = 0;
    int n_checks = 0;

    // Reference model: who owns the bus, whether this is a hand-over gap,
    // cycles already spent waiting, beats in this tenure, starvation flag.
    bit m_dma;
    bit m_gap;
    bit m_starve;
    int m_spent;
    int m_beats;

    logic        e_rdy, e_ack, e_gnt, e_cs, e_we, e_rw, e_slow, e_done;
    logic [15:0] e_addr;
    logic [7:0]  e_wdata;

    logic        s_cpu_rdy, s_dma_ack, s_dma_gnt, s_mem_cs, s_mem_we;
    logic [15:0] s_mem_address;

    function void model_reset();
        m_dma    = 1'b0;
        m_gap    = 1'b0;
        m_starve = 1'b0;
        m_spent  = 0;
        m_beats  = 0;
    endfunction

    function void model_eval();
        bit on_dma;
        bit on_cpu;
        on_dma  = !m_gap && m_dma;
        on_cpu  = !m_gap && !m_dma;
        e_addr  = on_dma ? dma_address : cpu_address;
        e_rw    = on_dma ? dma_READ_write : cpu_READ_write;
        e_wdata = on_dma ? dma_wdata : cpu_data_out;
        e_slow  = (e_addr >= SLOW_BASE);
        e_done  = (on_cpu || (on_dma && dma_req)) && (!e_slow || m_spent == SLOW_WAIT);
        e_rdy   = on_cpu && e_done;
        e_ack   = on_dma && e_done;
        e_gnt   = on_dma;
        e_cs    = !m_gap;
        e_we    = e_done && !e_rw && !reset;
    endfunction

    function void model_update();
        if (reset) begin
            model_reset();
        end else if (m_gap) begin
            m_gap   = 1'b0;
            m_spent = 0;
            m_beats = 0;
        end else if (!m_dma) begin
            if (e_done && cpu_READ_write && dma_req && !m_starve) begin
                m_gap   = 1'b1;
                m_dma   = 1'b1;
                m_spent = 0;
            end else if (e_done || !e_slow) begin
                m_spent = 0;
            end else begin
                m_spent = m_spent + 1;
            end
            if (e_done) m_starve = 1'b0;
        end else begin
            if (!dma_req) begin
                m_gap   = 1'b1;
                m_dma   = 1'b0;
                m_spent = 0;
            end else if (e_done) begin
                m_beats = m_beats + 1;
                m_spent = 0;
                if (m_beats == DMA_MAX_BURST) begin
                    m_gap    = 1'b1;
                    m_dma    = 1'b0;
                    m_starve = 1'b1;
                end
            end else if (!e_slow) begin
                m_spent = 0;
            end else begin
                m_spent = m_spent + 1;
            end
        end
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle: inputs already driven at the falling edge.
    task automatic step();
        #1;
        model_eval();
        s_cpu_rdy     = cpu_rdy;
        s_dma_ack     = dma_ack;
        s_dma_gnt     = dma_gnt;
        s_mem_cs      = mem_cs;
        s_mem_we      = mem_we;
        s_mem_address = mem_address;
        chk1("cpu_rdy", cpu_rdy, e_rdy);
        chk1("dma_ack", dma_ack, e_ack);
        chk1("dma_gnt", dma_gnt, e_gnt);
        chk1("mem_cs", mem_cs, e_cs);
        chk1("mem_we", mem_we, e_we);
        chk16("mem_address", mem_address, e_addr);
        chk16("mem_wdata", {8'h00, mem_wdata}, {8'h00, e_wdata});
        chk16("cpu_data_in", {8'h00, cpu_data_in}, {8'h00, mem_rdata});
        chk16("dma_rdata", {8'h00, dma_rdata}, {8'h00, mem_rdata});
        @(posedge clk_in);
        model_update();
        @(negedge clk_in);
    endtask

    function automatic logic [15:0] rand_addr();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 16'hBFFF;
        if (r == 1) return 16'hC000;
        if (r <= 3) return 16'(16'hC000 + 16'($urandom_range(0, 16'h3FFF)));
        return 16'($urandom_range(0, 16'hBFFF));
    endfunction

    initial begin
        int acks;
        int first_run;
        int between;
        int burst_left;
        bit seen_gnt;

        model_reset();
        reset          = 1'b1;
        cpu_READ_write = 1'b1;
        cpu_address    = 16'h0200;
        cpu_data_out   = 8'h00;
        dma_req        = 1'b0;
        dma_READ_write = 1'b1;
        dma_address    = 16'h0000;
        dma_wdata      = 8'h00;
        mem_rdata      = 8'h20;
        @(negedge clk_in);

        // Reset: fast decode drives cpu_rdy, bus selected, no write strobe.
        step();
        chk1("rst_cpu_rdy_fast", s_cpu_rdy, 1'b1);
        chk1("rst_mem_cs", s_mem_cs, 1'b1);
        chk1("rst_dma_gnt", s_dma_gnt, 1'b0);
        cpu_READ_write = 1'b0;
        cpu_address    = 16'h0100;
        step();
        chk1("rst_mem_we", s_mem_we, 1'b0);
        cpu_address = 16'hC000;
        step();
        chk1("rst_cpu_rdy_slow", s_cpu_rdy, 1'b0);
        reset = 1'b0;

        // Fast CPU read.
        cpu_READ_write = 1'b1;
        cpu_address    = 16'h0200;
        mem_rdata      = 8'h20;
        step();
        chk1("fast_rd_rdy", s_cpu_rdy, 1'b1);
        chk16("fast_rd_data", {8'h00, cpu_data_in}, 16'h0020);
        chk1("fast_rd_we", s_mem_we, 1'b0);

        // Slow CPU write: rdy 0,0,1 with the strobe only on the last cycle.
        cpu_READ_write = 1'b0;
        cpu_address    = 16'hC010;
        cpu_data_out   = 8'h05;
        step();
        chk1("slow_wr_rdy0", s_cpu_rdy, 1'b0);
        chk1("slow_wr_we0", s_mem_we, 1'b0);
        step();
        chk1("slow_wr_rdy1", s_cpu_rdy, 1'b0);
        chk1("slow_wr_we1", s_mem_we, 1'b0);
        step();
        chk1("slow_wr_rdy2", s_cpu_rdy, 1'b1);
        chk1("slow_wr_we2", s_mem_we, 1'b1);

        // DMA request during a CPU write: granted only after the next read.
        cpu_address  = 16'h0300;
        cpu_data_out = 8'h33;
        dma_req      = 1'b1;
        dma_READ_write = 1'b0;
        dma_address  = 16'h1234;
        dma_wdata    = 8'hA5;
        step();
        chk1("wr_no_grant_rdy", s_cpu_rdy, 1'b1);
        cpu_READ_write = 1'b1;
        cpu_address    = 16'h0200;
        step();
        chk1("rd_after_wr_rdy", s_cpu_rdy, 1'b1);
        step();
        chk1("handover_cs", s_mem_cs, 1'b0);
        chk1("handover_gnt", s_dma_gnt, 1'b0);
        chk1("handover_rdy", s_cpu_rdy, 1'b0);
        step();
        chk1("dma_gnt_on", s_dma_gnt, 1'b1);
        chk16("dma_addr_follow", s_mem_address, 16'h1234);
        dma_req = 1'b0;
        step();
        step();
        step();
        chk1("cpu_back_rdy", s_cpu_rdy, 1'b1);

        // 20-beat fast write burst against a 16-beat limit.
        acks      = 0;
        first_run = -1;
        between   = 0;
        seen_gnt  = 1'b0;
        for (int i = 0; i < 200 && acks < 20; i++) begin
            dma_req     = 1'b1;
            dma_address = 16'(16'h0400 + 16'(acks));
            dma_wdata   = 8'(acks);
            mem_rdata   = 8'($urandom);
            step();
            if (s_dma_ack) acks++;
            if (s_dma_gnt) seen_gnt = 1'b1;
            else if (seen_gnt && first_run < 0) first_run = acks;
            if (s_cpu_rdy && acks >= 16 && acks < 20) between++;
        end
        chk16("burst_total_acks", 16'(acks), 16'd20);
        chk16("burst_first_run", 16'(first_run), 16'd16);
        chk1("burst_cpu_between", between != 0, 1'b1);
        dma_req = 1'b0;
        step();
        step();
        step();

        // Slow DMA read abandoned on its second wait cycle.
        dma_req        = 1'b1;
        dma_READ_write = 1'b1;
        dma_address    = 16'hC100;
        step();
        step();
        step();
        chk1("slow_dma_wait0_ack", s_dma_ack, 1'b0);
        chk1("slow_dma_wait0_gnt", s_dma_gnt, 1'b1);
        dma_req = 1'b0;
        step();
        chk1("slow_dma_drop_ack", s_dma_ack, 1'b0);
        step();
        chk1("slow_dma_release_cs", s_mem_cs, 1'b0);
        step();
        chk1("slow_dma_cpu_resume", s_cpu_rdy, 1'b1);

        // Reset pulsed during beat 5 of a burst.
        dma_req        = 1'b1;
        dma_READ_write = 1'b0;
        dma_address    = 16'h0500;
        step();
        step();
        for (int b = 0; b < 4; b++) begin
            step();
            chk1("pre_reset_beat_ack", s_dma_ack, 1'b1);
        end
        #2;
        reset = 1'b1;
        #1;
        chk1("async_rst_gnt", dma_gnt, 1'b0);
        chk1("async_rst_ack", dma_ack, 1'b0);
        chk1("async_rst_cs", mem_cs, 1'b1);
        @(posedge clk_in);
        model_reset();
        @(negedge clk_in);
        reset   = 1'b0;
        dma_req = 1'b0;
        step();
        chk1("post_rst_cpu_rdy", s_cpu_rdy, 1'b1);

        // Random traffic against the model.
        burst_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (s_cpu_rdy) begin
                cpu_address    = rand_addr();
                cpu_READ_write = 1'($urandom_range(0, 1));
                cpu_data_out   = 8'($urandom);
            end
            if (!dma_req) begin
                if ($urandom_range(0, 5) == 0) begin
                    dma_req        = 1'b1;
                    burst_left     = int'($urandom_range(1, 24));
                    dma_address    = rand_addr();
                    dma_READ_write = 1'($urandom_range(0, 1));
                    dma_wdata      = 8'($urandom);
                end
            end else begin
                if (s_dma_ack) begin
                    burst_left--;
                    dma_address    = rand_addr();
                    dma_READ_write = 1'($urandom_range(0, 1));
                    dma_wdata      = 8'($urandom);
                end
                if (burst_left <= 0 || $urandom_range(0, 40) == 0) dma_req = 1'b0;
            end
            mem_rdata = 8'($urandom);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
